// File: rtl/encod_8_pra_3_sinc.sv
// ----------------------------------------------------------------------------
// encod_8_pra_3_sinc
//
// Purpose:
//   Synchronous, debounced 8-to-3 priority encoder. Raw request lines (keys or
//   switches) are registered, then a line pattern must stay stable for
//   DEB_CYCLES consecutive cycles before it is accepted. On acceptance the
//   index of the highest active line is emitted with a one-cycle valid pulse
//   and held until the lines have been released (also debounced).
//
// Parameters:
//   DEB_CYCLES - consecutive stable cycles needed to accept a press or a
//                release; legal range 1..255 (8-bit internal counter).
//
// Ports:
//   clk      in   1  system clock, rising edge
//   reset_n  in   1  synchronous active-low reset
//   in_lines in   8  raw request lines, active-high, bit 7 highest priority
//   code     out  3  index of the highest line in the accepted pattern
//   valid    out  1  one-cycle pulse when a new press is accepted
//   active   out  1  high while an accepted press is held
//   multi    out  1  more than one line set in the accepted pattern
// ----------------------------------------------------------------------------
module encod_8_pra_3_sinc #(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in_lines,
    output logic [2:0] code,
    output logic       valid,
    output logic       active,
    output logic       multi
);

    localparam logic [7:0] DEB = 8'(DEB_CYCLES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_sample;
    logic [7:0] r_snap,  w_snap_nxt;
    logic [7:0] r_cnt,   w_cnt_nxt;
    logic [2:0] r_code,  w_code_nxt;
    logic       r_valid, w_valid_nxt;
    logic       r_active, w_active_nxt;
    logic       r_multi, w_multi_nxt;

    logic       w_same;
    logic       w_zero;

    // Index of the highest set bit; later iterations overwrite earlier ones.
    function automatic logic [2:0] f_prio(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic f_multi(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

    assign w_same = (r_sample == r_snap);
    assign w_zero = (r_sample == 8'd0);

    // ------------------------------------------------------------------
    // State register (also holds the input sample and all output flops)
    // ------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values of the others, independent of order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_sample <= 8'd0;
            r_snap   <= 8'd0;
            r_cnt    <= 8'd0;
            r_code   <= 3'd0;
            r_valid  <= 1'b0;
            r_active <= 1'b0;
            r_multi  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sample <= in_lines;
            r_snap   <= w_snap_nxt;
            r_cnt    <= w_cnt_nxt;
            r_code   <= w_code_nxt;
            r_valid  <= w_valid_nxt;
            r_active <= w_active_nxt;
            r_multi  <= w_multi_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default at the top of the block;
    // a path that leaves one unassigned would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (!w_zero) w_state_nxt = DEBOUNCE;
            end
            DEBOUNCE: begin
                if (w_same) begin
                    if (r_cnt == DEB) w_state_nxt = PRESSED;
                end else if (w_zero) begin
                    w_state_nxt = IDLE;
                end
            end
            PRESSED: begin
                // Any nonzero pattern is ignored until a full release.
                if (w_zero) w_state_nxt = RELEASE;
            end
            RELEASE: begin
                // Lines reappearing during release are a bounce of the held key.
                if (!w_zero)            w_state_nxt = PRESSED;
                else if (r_cnt == DEB)  w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath logic: next values of the registered outputs,
    // the debounce counter and the pattern snapshot.
    // ------------------------------------------------------------------
    always_comb begin
        w_snap_nxt   = r_snap;
        w_cnt_nxt    = r_cnt;
        w_code_nxt   = r_code;
        w_multi_nxt  = r_multi;
        w_active_nxt = r_active;
        w_valid_nxt  = 1'b0;        // valid is a single-cycle pulse
        case (r_state)
            IDLE: begin
                if (!w_zero) begin
                    w_snap_nxt = r_sample;
                    w_cnt_nxt  = 8'd1;
                end
            end
            DEBOUNCE: begin
                if (w_same) begin
                    if (r_cnt == DEB) begin
                        w_code_nxt   = f_prio(r_snap);
                        w_multi_nxt  = f_multi(r_snap);
                        w_valid_nxt  = 1'b1;
                        w_active_nxt = 1'b1;
                    end else if (r_cnt < DEB) begin
                        w_cnt_nxt = r_cnt + 8'd1;   // saturates at DEB
                    end
                end else if (w_zero) begin
                    w_cnt_nxt = 8'd0;
                end else begin
                    // New pattern mid-debounce: restart the count on it.
                    w_snap_nxt = r_sample;
                    w_cnt_nxt  = 8'd1;
                end
            end
            PRESSED: begin
                if (w_zero) w_cnt_nxt = 8'd1;
            end
            RELEASE: begin
                if (w_zero) begin
                    if (r_cnt == DEB) begin
                        w_active_nxt = 1'b0;
                        w_cnt_nxt    = 8'd0;
                    end else if (r_cnt < DEB) begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            default: begin
                w_cnt_nxt = 8'd0;
            end
        endcase
    end

    assign code   = r_code;
    assign valid  = r_valid;
    assign active = r_active;
    assign multi  = r_multi;

endmodule

// File: doc/encod_8_pra_3_sinc.md
Name: encod_8_pra_3_sinc

Overview:
Synchronous, debounced 8-to-3 priority encoder; the inverse of the team's 3-to-8 decoder. It takes eight raw one-hot request lines (keys or switches) and requires the line pattern to be stable for a programmable number of cycles. It then emits the 3-bit index of the highest active line with a one-cycle valid pulse and holds it until the lines are released. It feeds the decoder and display paths in the project datapath.

Parameters:
DEB_CYCLES, 4, consecutive stable cycles required to accept a press or a release; legal range 1..255; internal counter is 8 bits.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  reset, synchronous, active-low.
in_lines  input  8  raw request lines, active-high; bit 7 has highest priority.
code  output  3  encoded index of the accepted line.
valid  output  1  one-cycle pulse when a new press is accepted.
active  output  1  high while an accepted press is held.
multi  output  1  high if more than one line was set in the accepted pattern.

Behaviour:
- One clock; reset is synchronous and active-low. While reset_n=0 at a rising edge, the block goes to the following values:
  - state=IDLE, sample=0, snap=0, cnt=0.
  - code=0, valid=0, active=0, multi=0.
- Input stage: every edge registers in_lines into sample. All decisions use sample, never in_lines directly.
- All outputs are registered.
- IDLE:
  - sample!=0 -> DEBOUNCE; snap<=sample, cnt<=1.
- DEBOUNCE:
  - sample==snap and cnt==DEB_CYCLES -> PRESSED. On the same edge: code<=prio(snap), multi<=(popcount(snap)>1), valid<=1, active<=1.
  - sample==snap and cnt<DEB_CYCLES -> cnt<=cnt+1.
  - sample!=snap and sample==0 -> IDLE, cnt<=0.
  - sample!=snap and sample!=0 -> snap<=sample, cnt<=1 (restart the count).
- PRESSED:
  - valid<=0 on the next edge; valid is exactly one cycle wide.
  - Any nonzero sample, including a different pattern, is ignored. No re-key happens until a full release.
  - sample==0 -> RELEASE, cnt<=1.
- RELEASE:
  - sample==0 and cnt==DEB_CYCLES -> IDLE, active<=0.
  - sample==0 and cnt<DEB_CYCLES -> cnt<=cnt+1.
  - sample!=0 -> PRESSED (treated as a bounce). No new valid; code and multi unchanged.
- prio(): index of the highest set bit, e.g. 8'b0010_0100 -> 5.
- code and multi hold their last values after returning to IDLE; they change only on an accepted press.
- Latency: in_lines changes to a nonzero value and stays stable. valid is high during the cycle after the (DEB_CYCLES+2)th rising edge that sees the new value. Example with DEB_CYCLES=1: edge0 sample, edge1 DEBOUNCE, edge2 PRESSED/valid.
- Release latency: active falls DEB_CYCLES+2 edges after in_lines goes to 0.
- Boundary conditions:
  - Glitch shorter than DEB_CYCLES+1 edges: no valid pulse, back to IDLE.
  - Pattern change mid-debounce: count restarts on the new pattern.
  - DEB_CYCLES=1 is legal.
  - Counter never wraps because it saturates at DEB_CYCLES.
  - Reset mid-operation: immediate return to reset values at that edge; valid is not asserted in that cycle; any pending press is discarded.

Test Plan:
- Reset: reset_n=0 for 2 edges with in_lines=8'hFF -> code=0, valid=0, active=0, multi=0; after release with lines still at 8'hFF, valid pulses with code=7, multi=1 at the specified latency.
- Clean press: DEB_CYCLES=4, in_lines=8'b0000_1000 held for 10 cycles -> valid high for exactly one cycle at edge 6, code=3, multi=0, active=1; in_lines=0 -> active falls 6 edges later; code stays 3.
- Bounce rejection: in_lines=8'h04 for 3 edges, then 0, then 8'h04 for 2 edges, then 0 -> no valid pulse, active stays 0, code unchanged.
- Priority/multi: in_lines=8'b1010_0000 stable -> code=7, multi=1; next press of 8'b0000_0001 -> code=0, multi=0.
- Held-change/release bounce: while PRESSED, switch in_lines 8'h02->8'h40 -> no valid, code stays 1; during RELEASE insert a 1-cycle 8'h02 -> state returns to PRESSED with no valid and active stays 1.
- Reset mid-debounce: assert reset_n=0 at cnt=2 -> all outputs 0 next cycle; no valid is ever emitted for that press.
